systolic_result_drain: RTL and testbench

Output-side companion to the array's input position counter. The block collects the skewed results leaving the bottom edge of the systolic array and realigns each column into whole rows. It buffers up to two aligned rows and serialises the matrix as a row-major, one-element-per-handshake stream tagged with row and column counters. It backpressures the array through a freeze signal when its row buffer is full.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/deskew_line.sv | 56 +++++
 rtl/systolic_result_drain.sv | 166 ++++++++++++++++
 tb/tb_systolic_result_drain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array input and output sides.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package systolic_pkg;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } drain_state_e;

endpackage

// File: rtl/deskew_line.sv
// Per-column data+valid delay line used to undo the array's output skew.
// Latency: DEPTH advances of en; DEPTH=0 is a plain wire.
// Backpressure: stages hold their contents while en is low.
module deskew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign out_vld = in_vld;
    assign out_dat = in_dat;
  end else begin : g_shift
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DATA_W-1:0] dat_d [DEPTH];

    // Shift one stage per enabled cycle, otherwise hold.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (en) begin
        vld_d[0] = in_vld;
        dat_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
    end

    // Valids are cleared on reset; data needs no reset.
    always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
    end

    // Data stages.
    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// De-skews array bottom-edge results into rows, buffers two rows, streams them row-major.
// Latency: first element valid WIDTH cycles after (row 0, col 0) is presented.
// Backpressure: stall freezes the array when both row slots are full; out_valid/out_ready handshake downstream.
// Optional: SYSTOLIC_DRAIN_SKEW_CHECK_EN enables the sticky skew_err checker.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               in_valid,
  input  logic [WIDTH*DATA_W-1:0]        in_data,
  output logic                           stall,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [clog2_min1(WIDTH)-1:0]   out_col,
  output logic [clog2_min1(HEIGHT)-1:0]  out_row,
  output logic                           out_last,
  output logic                           busy,
  output logic                           skew_err
);

  localparam int COL_W = clog2_min1(WIDTH);
  localparam int ROW_W = clog2_min1(HEIGHT);
  localparam int RIN_W = clog2_min1(HEIGHT + 1);

  drain_state_e      state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RIN_W-1:0]  rows_in_q, rows_in_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] fifo_q [2][WIDTH];
  logic [DATA_W-1:0] fifo_d [2][WIDTH];

  logic              advance, wr_en, handshake, pop;
  logic [WIDTH-1:0]  al_vld;
  logic [DATA_W-1:0] al_dat [WIDTH];

  assign stall     = (cnt_q == 2'd2);
  assign advance   = (state_q == RUN) && !stall;
  assign wr_en     = advance && al_vld[0] && (rows_in_q < RIN_W'(HEIGHT));
  assign out_valid = (cnt_q != 2'd0);
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && (col_q == COL_W'(WIDTH - 1));
  assign out_last  = out_valid && (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));
  assign out_data  = fifo_q[rd_ptr_q][col_q];
  assign out_col   = col_q;
  assign out_row   = row_q;
  assign busy      = (state_q == RUN);

  // Column c waits WIDTH-1-c stages so every column of a row lines up.
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    deskew_line #(
      .DEPTH  (WIDTH - 1 - c),
      .DATA_W (DATA_W)
    ) u_deskew (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .in_vld  (in_valid[c]),
      .in_dat  (in_data[c*DATA_W +: DATA_W]),
      .out_vld (al_vld[c]),
      .out_dat (al_dat[c])
    );
  end

  // Next state: start opens a matrix, the final handshake closes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (handshake && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row FIFO bookkeeping and the row/column output counters.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rows_in_d = rows_in_q;
    col_d     = col_q;
    row_d     = row_q;
    if (wr_en) begin
      fifo_d[wr_ptr_q] = al_dat;
      wr_ptr_d         = ~wr_ptr_q;
      rows_in_d        = rows_in_q + RIN_W'(1);
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if ((state_q == IDLE) && start) rows_in_d = '0;
    if (handshake) begin
      if (out_last) begin
        col_d = '0;
        row_d = '0;
      end else if (pop) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Control state registers; reset drops any buffered rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rows_in_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rows_in_q <= rows_in_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  // Row storage is qualified by cnt_q and needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
  logic skew_q, skew_d;

  // Flag any disagreement between column 0's aligned valid and the others.
  always_comb begin
    skew_d = skew_q;
    if (wr_en && !(&al_vld))              skew_d = 1'b1;
    if (advance && !al_vld[0] && |al_vld) skew_d = 1'b1;
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) skew_q <= 1'b0;
    else     skew_q <= skew_d;
  end

  assign skew_err = skew_q;
`else
  logic unused_vld;
  assign unused_vld = ^al_vld;
  assign skew_err   = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomised bench for systolic_result_drain against a row-major matrix reference.
// Latency: checks first out_valid at t0+WIDTH for the directed case.
// Backpressure: exercises stall, toggled and random out_ready.
module tb_systolic_result_drain;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    in_valid;
  logic [W*DW-1:0] in_data;
  logic            stall;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_col;
  logic [0:0]      out_row;
  logic            out_last;
  logic            busy;
  logic            skew_err;

  systolic_result_drain #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .stall     (stall),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .skew_err  (skew_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] mat [H+1][W];
  bit skew_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Skewed array model: at array time k, column c shows row k-c.
  task automatic drive_array(input int k, input int nrows, input int drop_r, input int drop_c);
    for (int c = 0; c < W; c++) begin
      int r;
      r = k - c;
      if (r >= 0 && r < nrows) begin
        in_valid[c]          = !(r == drop_r && c == drop_c);
        in_data[c*DW +: DW]  = mat[r][c];
      end else begin
        in_valid[c]          = 1'b0;
        in_data[c*DW +: DW]  = $urandom;
      end
    end
  endtask

  task automatic fill_mat(input bit directed);
    for (int r = 0; r <= H; r++)
      for (int c = 0; c < W; c++)
        mat[r][c] = directed ? DW'(10 * r + c) : $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_stall"},     stall,     0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_out_col"},   out_col,   0);
    chk({tag, "_out_row"},   out_row,   0);
    chk({tag, "_skew_err"},  skew_err,  0);
  endtask

  // One matrix. Called and returns at #1 after a rising edge.
  // mode: 0 ready=1, 1 toggle, 2 held low for 25 cycles, 3 random.
  task automatic run_matrix(input int nrows, input int mode, input int drop_r, input int drop_c,
                            input int rst_after, input bit start_on_last, input bit check_lat);
    int k, cyc, hs, first_vld;
    bit done, prev_hold, saw_stall, hs_now;
    logic [DW-1:0] p_dat;
    logic [1:0] p_col;
    logic p_row, p_last;
    k = -2; cyc = 0; hs = 0; first_vld = -1;
    done = 0; prev_hold = 0; saw_stall = 0;
    p_dat = '0; p_col = '0; p_row = 1'b0; p_last = 1'b0;
    while (!done && cyc < 2000) begin
      if (rst_after >= 0 && hs == rst_after) begin
        rst = 1'b1; start = 1'b0; in_valid = '0;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        skew_exp = 1'b0;
        return;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (stall) saw_stall = 1'b1;
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data",  out_data,  p_dat);
        chk("hold_col",   out_col,   p_col);
        chk("hold_row",   out_row,   p_row);
        chk("hold_last",  out_last,  p_last);
      end
      start = (cyc == 0) || (cyc == 4);
      unique case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        2:       out_ready = (cyc >= 25);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && cyc == 24) begin
        chk("stall_full", stall, 1);
        chk("stall_no_hs", hs, 0);
      end
      drive_array(k, nrows, drop_r, drop_c);
      hs_now = out_valid && out_ready;
      if (hs_now) begin
        if (hs < H * W) begin
          chk("data", out_data, mat[hs / W][hs % W]);
          chk("row",  out_row,  hs / W);
          chk("col",  out_col,  hs % W);
          chk("last", out_last, (hs == H * W - 1));
        end else begin
          chk("extra_handshake", hs, H * W - 1);
        end
        hs++;
        if (out_last) begin
          done = 1'b1;
          chk("busy_on_last", busy, 1);
          if (start_on_last) start = 1'b1;
        end
      end
      prev_hold = out_valid && !out_ready;
      p_dat = out_data; p_col = out_col; p_row = out_row; p_last = out_last;
      if (!stall) k++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
    chk("hs_count", hs, H * W);
    if (check_lat) chk("first_valid_cycle", first_vld, 2 + W);
    if (mode == 2) chk("saw_stall", saw_stall, 1);
`ifdef SYSTOLIC_DRAIN_SKEW_CHECK_EN
    if (drop_r >= 0) skew_exp = 1'b1;
`endif
    chk("skew_err", skew_err, skew_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    fill_mat(1'b1);
    run_matrix(H, 0, -1, -1, -1, 1'b1, 1'b1);
    fill_mat(1'b0);
    run_matrix(H, 2, -1, -1, -1, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H, 1, -1, -1, -1, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H + 1, 0, -1, -1, -1, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H, 0, 1, 2, -1, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H, 3, -1, -1, -1, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H, 0, -1, -1, 5, 1'b0, 1'b0);
    fill_mat(1'b0);
    run_matrix(H, 0, -1, -1, -1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fill_mat(1'b0);
      run_matrix((i % 2 == 0) ? H : H + 1, 3, -1, -1, -1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
